mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the 32 x 4 data memory. It arbitrates between two requesters, such as the CPU datapath and a program loader or debug port, using round-robin. It latches the winning request, drives the memory write-enable, address and write-data for exactly one cycle, and returns a registered response to the requester under a valid/ready handshake. It sits between the requesters and the single-port memory, which has a synchronous write and a combinational read.

---
 rtl/mem_arbiter_if.sv | 24 ++
 rtl/mem_arbiter.sv | 95 +++++++++
 tb/tb_mem_arbiter.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester request/response handshake bundle for mem_arbiter
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 4
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin two-port arbiter and sequencer for the single-port data memory
module mem_arbiter #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_arbiter_if.slave          r0,
  mem_arbiter_if.slave          r1,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  we_q;
  logic                  owner_q;
  logic                  last_grant;
  logic                  rsp_valid_q;

  logic any_valid;
  logic grant;
  logic accept;
  logic owner_ready;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    any_valid   = r0.req_valid | r1.req_valid;
    grant       = (r0.req_valid & r1.req_valid) ? ~last_grant : r1.req_valid;
    accept      = (state == IDLE) & any_valid;
    owner_ready = owner_q ? r1.rsp_ready : r0.rsp_ready;
  end

  assign r0.req_ready = accept & ~grant;
  assign r1.req_ready = accept & grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      we_q        <= 1'b0;
      owner_q     <= 1'b0;
      last_grant  <= 1'b1;
      rsp_valid_q <= 1'b0;
      mem_we      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner_q    <= grant;
            last_grant <= grant;
            we_q       <= grant ? r1.req_we    : r0.req_we;
            addr_q     <= grant ? r1.req_addr  : r0.req_addr;
            wdata_q    <= grant ? r1.req_wdata : r0.req_wdata;
            mem_we     <= grant ? r1.req_we    : r0.req_we;
            state      <= EXEC;
          end
        end
        EXEC: begin
          // The write commits at this edge; a read captures the combinational memory output.
          mem_we      <= 1'b0;
          rdata_q     <= we_q ? wdata_q : mem_data_out;
          rsp_valid_q <= 1'b1;
          state       <= RESP;
        end
        RESP: begin
          if (owner_ready) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign mem_addr     = addr_q;
  assign mem_data_in  = wdata_q;
  assign busy         = (state != IDLE);

  assign r0.rsp_valid = rsp_valid_q & ~owner_q;
  assign r1.rsp_valid = rsp_valid_q & owner_q;
  assign r0.rsp_rdata = owner_q ? '0 : rdata_q;
  assign r1.rsp_rdata = owner_q ? rdata_q : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter with a behavioural 32 x 4 memory
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out;
  logic          busy;
  logic [DW-1:0] mem [0:31];

  int total = 0;
  int bad   = 0;
  int g [0:7];
  int ng, n0, n1;

  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b0 ();
  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) b1 ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .r0           (b0),
    .r1           (b1),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out),
    .busy         (busy)
  );

  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_data_in;
  assign mem_data_out = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic we, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (p == 0) begin
      b0.req_valid = v; b0.req_we = we; b0.req_addr = a; b0.req_wdata = d;
    end else begin
      b1.req_valid = v; b1.req_we = we; b1.req_addr = a; b1.req_wdata = d;
    end
  endtask

  task automatic set_rr(input int p, input logic v);
    if (p == 0) b0.rsp_ready = v;
    else        b1.rsp_ready = v;
  endtask

  function automatic logic rdy(input int p);
    return (p == 0) ? b0.req_ready : b1.req_ready;
  endfunction

  function automatic logic rspv(input int p);
    return (p == 0) ? b0.rsp_valid : b1.rsp_valid;
  endfunction

  function automatic logic [DW-1:0] rdat(input int p);
    return (p == 0) ? b0.rsp_rdata : b1.rsp_rdata;
  endfunction

  // One full transaction from an idle arbiter: accept, EXEC, RESP, back to IDLE.
  task automatic txn(input int p, input logic we, input logic [AW-1:0] a,
                     input logic [DW-1:0] d, input logic [DW-1:0] exp);
    @(negedge clk);
    drive(p, 1'b1, we, a, d);
    #1;
    check("req_ready", rdy(p), 1);
    check("req_ready_other", rdy(1 - p), 0);
    @(negedge clk);
    drive(p, 1'b0, 1'b0, '0, '0);
    check("exec_we", mem_we, we);
    check("exec_addr", mem_addr, a);
    check("exec_din", mem_data_in, d);
    check("exec_busy", busy, 1);
    check("exec_no_ready", b0.req_ready | b1.req_ready, 0);
    check("exec_no_rsp", rspv(p), 0);
    @(negedge clk);
    check("resp_valid", rspv(p), 1);
    check("resp_valid_other", rspv(1 - p), 0);
    check("resp_rdata", rdat(p), exp);
    check("resp_rdata_other", rdat(1 - p), 0);
    check("resp_we_low", mem_we, 0);
    set_rr(p, 1'b1);
    @(negedge clk);
    set_rr(p, 1'b0);
    check("idle_busy", busy, 0);
    check("idle_rsp_valid", rspv(p), 0);
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    b0.rsp_ready = 1'b0;
    b1.rsp_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_din", mem_data_in, 0);
    check("rst_rsp", {b0.rsp_valid, b1.rsp_valid, b0.rsp_rdata, b1.rsp_rdata}, 0);
    check("rst_ready", {b0.req_ready, b1.req_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_busy", busy, 0);
    check("post_rst_ready", {b0.req_ready, b1.req_ready}, 0);

    // 1: r0 write then read; preload addresses used later
    txn(0, 1, 5'd5, 4'hA, 4'hA);
    txn(0, 0, 5'd5, 4'h0, 4'hA);
    txn(0, 1, 5'd3, 4'h4, 4'h4);
    txn(0, 1, 5'd7, 4'h9, 4'h9);

    // 2: continuous contention after reset alternates r0, r1, r0, r1
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(0, 1, 0, 5'd3, 4'h0);
    drive(1, 1, 0, 5'd7, 4'h0);
    b0.rsp_ready = 1'b1;
    b1.rsp_ready = 1'b1;
    ng = 0; n0 = 0; n1 = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      check("both_ready", b0.req_ready & b1.req_ready, 0);
      check("both_rsp_valid", b0.rsp_valid & b1.rsp_valid, 0);
      if (b0.req_ready && ng < 8) begin g[ng] = 0; ng++; end
      if (b1.req_ready && ng < 8) begin g[ng] = 1; ng++; end
      if (b0.rsp_valid) begin check("rr_rdata0", b0.rsp_rdata, 4'h4); n0++; end
      if (b1.rsp_valid) begin check("rr_rdata1", b1.rsp_rdata, 4'h9); n1++; end
      @(negedge clk);
    end
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    repeat (4) @(negedge clk);
    b0.rsp_ready = 1'b0;
    b1.rsp_ready = 1'b0;
    check("rr_grant_count", (ng >= 4) ? 1 : 0, 1);
    for (int i = 0; i < 4; i++) check("rr_order", g[i], i % 2);
    check("rr_rsp0_seen", (n0 >= 2) ? 1 : 0, 1);
    check("rr_rsp1_seen", (n1 >= 2) ? 1 : 0, 1);

    // 3: r1 response held; r0 waiting must not be granted, r0 rsp_ready ignored
    @(negedge clk);
    drive(1, 1, 0, 5'd7, 4'h0);
    #1;
    check("hold_accept", b1.req_ready, 1);
    @(negedge clk);
    drive(1, 0, 0, '0, '0);
    drive(0, 1, 0, 5'd3, 4'h0);
    b0.rsp_ready = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) begin
      #1;
      check("hold_valid", b1.rsp_valid, 1);
      check("hold_rdata", b1.rsp_rdata, 4'h9);
      check("hold_ready", {b0.req_ready, b1.req_ready}, 0);
      check("hold_busy", busy, 1);
      check("hold_we", mem_we, 0);
      check("hold_r0_rsp", {b0.rsp_valid, b0.rsp_rdata}, 0);
      @(negedge clk);
    end
    drive(0, 0, 0, '0, '0);
    b0.rsp_ready = 1'b0;
    b1.rsp_ready = 1'b1;
    @(negedge clk);
    b1.rsp_ready = 1'b0;
    #1;
    check("release_busy", busy, 0);
    check("release_valid", b1.rsp_valid, 0);

    // 4: boundary addresses
    txn(0, 1, 5'd31, 4'hF, 4'hF);
    txn(1, 1, 5'd0, 4'h1, 4'h1);
    txn(0, 0, 5'd31, 4'h0, 4'hF);
    txn(1, 0, 5'd0, 4'h0, 4'h1);

    // 5: reset during EXEC of a write must not commit
    txn(0, 1, 5'd9, 4'h2, 4'h2);
    @(negedge clk);
    drive(0, 1, 1, 5'd9, 4'h6);
    #1;
    check("abort_accept", b0.req_ready, 1);
    @(negedge clk);
    drive(0, 0, 0, '0, '0);
    check("abort_exec_we", mem_we, 1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_we_async", mem_we, 0);
    check("abort_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_no_rsp", {b0.rsp_valid, b1.rsp_valid}, 0);
    check("abort_idle", busy, 0);
    txn(0, 0, 5'd9, 4'h0, 4'h2);

    // 6: r1 alone, successive writes, then read back through r0
    txn(1, 1, 5'd10, 4'h3, 4'h3);
    txn(1, 1, 5'd11, 4'hC, 4'hC);
    txn(1, 1, 5'd12, 4'h5, 4'h5);
    txn(0, 0, 5'd10, 4'h0, 4'h3);
    txn(0, 0, 5'd11, 4'h0, 4'hC);
    txn(0, 0, 5'd12, 4'h0, 4'h5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
